// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Write-side companion to the instruction memory. Accepts a byte stream over a
// valid/ready handshake, packs every four bytes into a little-endian 32-bit
// instruction word, and writes the words into consecutive memory slots
// starting at word 0. While a load is running, the core's fetch stage is held
// off the memory.
//
// Ports
//   clk         single clock; all state changes on the rising edge
//   rst         synchronous, active-low reset
//   start       one-cycle load request (only looked at in IDLE)
//   load_len    number of words to load, captured with start (legal 1..DEPTH)
//   abort       one-cycle request to cancel a load in progress
//   byte_valid  byte_data carries a byte
//   byte_data   incoming byte
//   byte_ready  loader accepts a byte at the next edge
//   write_en    instruction-memory write strobe (one cycle per word)
//   write_addr  word address of the write
//   write_data  assembled instruction word
//   busy        high from the accepted start until the return to IDLE
//   core_hold   fetch stall / flush; identical to busy
//   done        one-cycle pulse after the final word has been written
//   error       sticky flag: illegal load_len or abort; cleared by a legal start
//
// Every output is a flop or a copy of a flop; no input reaches an output
// combinationally.
// -----------------------------------------------------------------------------
module imem_loader #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   load_len,
  input  logic              abort,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              write_en,
  output logic [ADDR_W-1:0] write_addr,
  output logic [31:0]       write_data,
  output logic              busy,
  output logic              core_hold,
  output logic              done,
  output logic              error
);

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    WRITE,
    DONE
  } state_t;

  localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W + 1)'(DEPTH);

  state_t            state;
  logic [ADDR_W:0]   len_q;      // captured load length
  logic [ADDR_W-1:0] word_addr;  // slot the word being received goes to
  logic [1:0]        byte_cnt;   // index of the next byte within the word
  logic [23:0]       asm_q;      // bytes 0..2 of the word; byte 3 lands straight in write_data
  logic              last_word;

  // The word just assembled is the final one of the load.
  assign last_word = ({1'b0, word_addr} == (len_q - 1'b1));

  assign core_hold = busy;

  // NOTE: every register below is assigned with <= so all of them update from
  // the same pre-edge values; blocking assignments here would let later
  // statements see half-updated state and make the result order-dependent.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      len_q      <= '0;
      word_addr  <= '0;
      byte_cnt   <= '0;
      asm_q      <= '0;
      byte_ready <= 1'b0;
      write_en   <= 1'b0;
      write_addr <= '0;
      write_data <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      // Strobes default low; the state that raises them holds them one cycle.
      write_en <= 1'b0;
      done     <= 1'b0;

      unique case (state)
        IDLE: begin
          // A start that arrives together with abort is dropped entirely.
          if (start && !abort) begin
            if (load_len == '0 || load_len > MAX_LEN) begin
              error <= 1'b1;
            end else begin
              state      <= RECV;
              len_q      <= load_len;
              word_addr  <= '0;
              byte_cnt   <= '0;
              asm_q      <= '0;
              error      <= 1'b0;
              busy       <= 1'b1;
              byte_ready <= 1'b1;
            end
          end
        end

        RECV: begin
          if (abort) begin
            // Any partially received word is simply forgotten.
            state      <= IDLE;
            byte_cnt   <= '0;
            byte_ready <= 1'b0;
            busy       <= 1'b0;
            error      <= 1'b1;
          end else if (byte_valid && byte_ready) begin
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              // Fourth byte completes the word: present it on the write port.
              write_data <= {byte_data, asm_q};
              write_addr <= word_addr;
              write_en   <= 1'b1;
              byte_ready <= 1'b0;
              state      <= WRITE;
            end else begin
              // Shift right so byte 0 ends up in the least significant lane.
              asm_q <= {byte_data, asm_q[23:8]};
            end
          end
        end

        WRITE: begin
          // write_en is already high in this cycle, so an abort here still
          // lets the write complete.
          if (abort) begin
            state      <= IDLE;
            byte_cnt   <= '0;
            busy       <= 1'b0;
            error      <= 1'b1;
          end else if (last_word) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            word_addr  <= word_addr + 1'b1;
            byte_ready <= 1'b1;
            state      <= RECV;
          end
        end

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//
// Directed bench for imem_loader. A small model keeps the list of words that
// must appear on the write port (address, data, whether it is the final word
// of its load), built from the bytes the bench sends with plain arithmetic.
// A compare process checks every write and the done pulse against that list
// each cycle; scenario code adds literal expectations for timing and data.
// -----------------------------------------------------------------------------
module tb_imem_loader;

  localparam int DEPTH  = 256;
  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W:0]   load_len = '0;
  logic              abort = 1'b0;
  logic              byte_valid = 1'b0;
  logic [7:0]        byte_data = '0;
  logic              byte_ready;
  logic              write_en;
  logic [ADDR_W-1:0] write_addr;
  logic [31:0]       write_data;
  logic              busy;
  logic              core_hold;
  logic              done;
  logic              error;

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .load_len   (load_len),
    .abort      (abort),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .write_en   (write_en),
    .write_addr (write_addr),
    .write_data (write_data),
    .busy       (busy),
    .core_hold  (core_hold),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------- checking
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ------------------------------------------------------------------- model
  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    bit                last;
  } wr_t;

  wr_t exp_q[$];
  int  model_addr = 0;
  int  model_len  = 0;
  bit  model_err  = 1'b0;

  // Observations made by the compare process.
  bit                cmp_en = 1'b0;
  bit                exp_done_now = 1'b0;
  int                writes = 0;
  int                dones = 0;
  int                write_cyc = 0;
  int                done_cyc = 0;
  int                start_cyc = 0;
  logic [ADDR_W-1:0] last_write_addr = '0;
  logic [31:0]       last_write_data = '0;

  always @(negedge clk) begin
    if (cmp_en) begin
      wr_t e;
      check("core_hold_eq_busy", 32'(core_hold), 32'(busy));
      // done must follow the final write by exactly one cycle, and only then.
      check("done", 32'(done), 32'(exp_done_now));
      if (done) begin
        dones++;
        done_cyc = cyc;
      end
      exp_done_now = 1'b0;
      if (write_en) begin
        writes++;
        write_cyc       = cyc;
        last_write_addr = write_addr;
        last_write_data = write_data;
        if (exp_q.size() == 0) begin
          check("unexpected_write", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("write_addr", 32'(write_addr), 32'(e.addr));
          check("write_data", write_data, e.data);
          exp_done_now = e.last;
        end
      end
    end
  end

  // --------------------------------------------------------------- stimulus
  task automatic do_start(input int len, input bit with_abort);
    start    = 1'b1;
    abort    = with_abort;
    load_len = len[ADDR_W:0];
    @(posedge clk); #1;
    start     = 1'b0;
    abort     = 1'b0;
    start_cyc = cyc;
    if (!with_abort) begin
      if (len >= 1 && len <= DEPTH) begin
        model_addr = 0;
        model_len  = len;
        model_err  = 1'b0;
      end else begin
        model_err = 1'b1;
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit acc;
    bit ok;
    byte_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
    byte_valid = 1'b1;
    byte_data  = b;
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      acc = byte_ready;  // value the upcoming edge will see
      @(posedge clk); #1;
      if (acc) begin
        ok = 1'b1;
        break;
      end
    end
    byte_valid = 1'b0;
    if (!ok) check("byte_accept_timeout", 32'd0, 32'd1);
  endtask

  // Sends one word LSB first and records the write it must cause.
  task automatic send_word(input logic [31:0] w, input int max_gap);
    wr_t e;
    for (int k = 0; k < 4; k++)
      send_byte(w[8*k +: 8], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
    e.addr = ADDR_W'(model_addr);
    e.data = w;
    e.last = (model_addr == model_len - 1);
    exp_q.push_back(e);
    model_addr++;
  endtask

  task automatic wait_done(input int budget, input int d0);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #3;
      if (dones > d0) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // --------------------------------------------------------------- scenarios
  initial begin
    int w0;
    int d0;
    logic [31:0] words3 [3];
    logic [31:0] w;
    words3[0] = 32'h00500093;
    words3[1] = 32'h00100113;
    words3[2] = 32'h002081B3;

    // Reset with noisy inputs for two edges.
    for (int i = 0; i < 2; i++) begin
      start      = 1'($urandom);
      abort      = 1'($urandom);
      byte_valid = 1'($urandom);
      byte_data  = 8'($urandom);
      load_len   = (ADDR_W + 1)'($urandom_range(1, DEPTH));
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("rst_byte_ready", 32'(byte_ready), 32'd0);
    check("rst_write_en",   32'(write_en),   32'd0);
    check("rst_write_addr", 32'(write_addr), 32'd0);
    check("rst_write_data", write_data,      32'd0);
    check("rst_busy",       32'(busy),       32'd0);
    check("rst_core_hold",  32'(core_hold),  32'd0);
    check("rst_done",       32'(done),       32'd0);
    check("rst_error",      32'(error),      32'd0);
    start = 1'b0; abort = 1'b0; byte_valid = 1'b0; byte_data = '0; load_len = '0;
    rst = 1'b1;
    @(posedge clk); #1;
    cmp_en = 1'b1;
    idle_cycles(2);

    // Single word, back-to-back bytes: write 4 edges and done 5 edges after start.
    w0 = writes; d0 = dones;
    do_start(1, 1'b0);
    send_word(32'h00000013, 0);
    wait_done(20, d0);
    check("single_write_latency", 32'(write_cyc - start_cyc), 32'd4);
    check("single_done_latency",  32'(done_cyc - start_cyc),  32'd5);
    check("single_busy_after",    32'(busy),       32'd0);
    check("single_ready_after",   32'(byte_ready), 32'd0);
    check("single_addr",          32'(last_write_addr), 32'd0);
    check("single_data",          last_write_data, 32'h00000013);
    check("single_writes",        32'(writes - w0), 32'd1);
    idle_cycles(3);
    check("single_dones",         32'(dones - d0),  32'd1);
    check("single_error",         32'(error), 32'(model_err));

    // Three words with random gaps in byte_valid.
    w0 = writes; d0 = dones;
    do_start(3, 1'b0);
    for (int i = 0; i < 3; i++) send_word(words3[i], 3);
    wait_done(60, d0);
    idle_cycles(10);
    check("multi_writes",   32'(writes - w0), 32'd3);
    check("multi_dones",    32'(dones - d0),  32'd1);
    check("multi_last_addr", 32'(last_write_addr), 32'd2);
    check("multi_last_data", last_write_data, 32'h002081B3);
    check("multi_queue_empty", 32'(exp_q.size()), 32'd0);
    check("multi_busy_after", 32'(busy), 32'd0);

    // Illegal lengths, then start+abort (ignored), then a legal start.
    w0 = writes;
    do_start(0, 1'b0);
    @(negedge clk);
    check("len0_error", 32'(error), 32'd1);
    check("len0_busy",  32'(busy),  32'd0);
    @(posedge clk); #1;
    do_start(257, 1'b0);
    @(negedge clk);
    check("len257_error", 32'(error), 32'd1);
    check("len257_busy",  32'(busy),  32'd0);
    check("len257_ready", 32'(byte_ready), 32'd0);
    @(posedge clk); #1;
    do_start(1, 1'b1);
    @(negedge clk);
    check("start_abort_busy",  32'(busy),  32'd0);
    check("start_abort_error", 32'(error), 32'd1);
    check("illegal_no_write",  32'(writes - w0), 32'd0);
    @(posedge clk); #1;
    d0 = dones;
    do_start(2, 1'b0);
    @(negedge clk);
    check("legal_clears_error", 32'(error), 32'd0);
    check("legal_busy",         32'(busy),  32'd1);
    @(posedge clk); #1;
    send_word(32'h11223344, 0);
    send_word(32'h55667788, 2);
    wait_done(40, d0);
    check("legal_last_data", last_write_data, 32'h55667788);
    // abort alone in IDLE does nothing.
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    check("idle_abort_error", 32'(error), 32'd0);
    check("idle_abort_busy",  32'(busy),  32'd0);
    @(posedge clk); #1;

    // Abort in the middle of the second word.
    w0 = writes; d0 = dones;
    do_start(2, 1'b0);
    send_word(32'h00500093, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    model_err = 1'b1;
    @(negedge clk);
    check("abort_busy",  32'(busy),  32'd0);
    check("abort_error", 32'(error), 32'(model_err));
    check("abort_ready", 32'(byte_ready), 32'd0);
    idle_cycles(5);
    check("abort_writes", 32'(writes - w0), 32'd1);
    check("abort_addr",   32'(last_write_addr), 32'd0);
    check("abort_dones",  32'(dones - d0), 32'd0);
    // The next load starts over at address 0 with a fresh byte count.
    d0 = dones;
    do_start(1, 1'b0);
    send_word(32'hDEADBEEF, 0);
    wait_done(20, d0);
    check("restart_addr",  32'(last_write_addr), 32'd0);
    check("restart_data",  last_write_data, 32'hDEADBEEF);
    check("restart_error", 32'(error), 32'd0);

    // Abort landing on the WRITE cycle: the write still happens.
    w0 = writes; d0 = dones;
    do_start(2, 1'b0);
    send_word(32'hCAFEF00D, 0);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    model_err = 1'b1;
    @(negedge clk);
    check("wabort_busy",  32'(busy),  32'd0);
    check("wabort_error", 32'(error), 32'(model_err));
    idle_cycles(5);
    check("wabort_writes", 32'(writes - w0), 32'd1);
    check("wabort_data",   last_write_data, 32'hCAFEF00D);
    check("wabort_dones",  32'(dones - d0), 32'd0);

    // Full depth, incrementing byte pattern, back-to-back.
    w0 = writes; d0 = dones;
    do_start(DEPTH, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      w = {8'(4*i + 3), 8'(4*i + 2), 8'(4*i + 1), 8'(4*i)};
      send_word(w, 0);
    end
    wait_done(20, d0);
    idle_cycles(5);
    check("full_writes",    32'(writes - w0), 32'(DEPTH));
    check("full_last_addr", 32'(last_write_addr), 32'(DEPTH - 1));
    check("full_last_data", last_write_data, 32'hFFFEFDFC);
    check("full_dones",     32'(dones - d0), 32'd1);
    // Counting the start edge itself: 1 + 5 cycles per word.
    check("full_cycles",    32'(done_cyc - start_cyc + 1), 32'(1 + 5 * DEPTH));
    check("full_busy_after", 32'(busy), 32'd0);
    check("full_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
